ysyx_25030093_csr_file: RTL and testbench
=========================================

Name: ysyx_25030093_csr_file

Overview:
- Parametrised machine-mode CSR file; next generation of the core's CSR register block.
- Serves CSRRW/CSRRS/CSRRC requests over a valid/ready handshake with registered responses.
- Performs atomic trap entry and mret, and drives a PC redirect to fetch.
- Sits beside the GPR file in EXU; the only owner of mtvec/mepc/mcause/mstatus/mscratch.

Parameters:
XLEN, 32, CSR data width (32 or 64)
MSTATUS_RST, 32'h0000_1800, mstatus reset value (MPP=3)
MTVEC_RST, 32'h0, mtvec reset value
CAUSE_W, 5, width of trap cause code input

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  CSR access request
req_ready  out  1  block can accept a request
req_op  in  2  0=none/read, 1=RW, 2=RS, 3=RC
req_addr  in  12  CSR address
req_wdata  in  XLEN  rs1 value or zero-extended uimm
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  XLEN  old CSR value
rsp_illegal  out  1  unimplemented address
trap_valid  in  1  trap entry pulse (ecall/exception/interrupt)
trap_intr  in  1  trap is an interrupt
trap_cause  in  CAUSE_W  cause code (ecall=11)
trap_pc  in  XLEN  pc of the trapping instruction
mret_valid  in  1  mret pulse
redir_valid  out  1  one-cycle redirect pulse
redir_pc  out  XLEN  redirect target
mstatus_mie  out  1  current mstatus.MIE

Behaviour:
- Reset is asynchronous and active-high. On reset: mstatus=MSTATUS_RST, mtvec=MTVEC_RST, and mepc/mcause/mscratch=0. FSM=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_illegal=0, redir_valid=0, redir_pc=0.
- Address map: 0x300 mstatus, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause. Any other address: rsp_illegal=1, rdata=0, no write.
- FSM states: IDLE and RESP.
  - IDLE: req_ready=1. On req_valid, read the old value, apply the write, register the response, and go to RESP. Latency is one cycle.
  - RESP: rsp_valid=1 with rdata/illegal held stable; req_ready=0. Leave when rsp_ready=1, returning to IDLE.
- Write rules: RW writes wdata; RS writes old|wdata; RC writes old&~wdata.
  - RS/RC with wdata==0 performs no write.
  - op=0 is a read only.
- mepc bits [1:0] are forced to 0 on every write. mtvec[1:0] is the mode field: 0=direct, 1=vectored; values 2 and 3 are written as 0.
- Trap entry, in one cycle on trap_valid:
  - mepc=trap_pc&~3.
  - mcause={trap_intr, zero-extended cause}, with the interrupt flag in bit XLEN-1.
  - MPIE=MIE, MIE=0, MPP=3.
  - Next cycle: redir_valid=1, with redir_pc = base if direct, or base+4*cause if vectored and trap_intr=1 (base = mtvec&~3).
- mret: MIE=MPIE, MPIE=1, MPP=0 (reads back 3, since only M-mode exists). Next cycle: redir_valid=1, redir_pc=mepc.
- Priority in a single cycle: trap > mret > CSR write.
  - A request accepted in the same cycle as a trap/mret still completes its response, but its write is dropped, and rsp_illegal is unchanged.
  - trap and mret together: the trap wins and mret is ignored.
- Trap or mret while in RESP: the architectural update happens; the pending response is unaffected.
- redir_pc for mret uses the mepc value before any same-cycle write; CSR writes are suppressed by priority anyway.
- Reset asserted mid-RESP: the response is discarded and state returns to reset values immediately.

Optional Feature:
- Macro CSR_MCYCLE_EN.
- When defined: 64-bit mcycle counter, incrementing every clk and reset to 0. Address 0xB00 reads/writes the low XLEN bits; 0xB80 reads/writes the high 32 bits (XLEN=32 only).
  - A write to one half takes effect in place of that cycle's increment; the other half still carries.
  - Wrap from all-ones to 0.
- When undefined: 0xB00/0xB80 are illegal and no counter flops exist.

Decomposition:
- Package ysyx_25030093_csr_pkg:
  - CSR address localparams.
  - req_op encoding enum.
  - FSM state enum.
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11).
  - Cause codes (ECALL_M=11).
- One sub-module, ysyx_25030093_csr_alu: combinational RW/RS/RC new-value and write-enable computation.

Test Plan:
- Reset then read 0x300 with rsp_ready=1 -> rsp_valid one cycle later, rdata=0x1800, illegal=0.
- RW 0x305 with 0x8000_0001, then trap_valid, cause=7, intr=1 -> redir_pc=0x8000_001C, mcause=0x8000_0007, MIE=0.
- Write mstatus=0x1808; ecall (cause 11, pc 0x8000_0100) then mret -> trap redirect to the mtvec base, mepc=0x8000_0100, mret redir_pc=0x8000_0100, mstatus=0x0088 (reads 0x1888 with MPP=3).
- RS 0x340 with 0xF0 over mscratch=0x0F, holding rsp_ready=0 for 3 cycles -> rsp_valid stays high, rdata=0x0F stable, req_ready=0; mscratch=0xFF afterwards.
- Access 0x7C0 -> rsp_illegal=1, rdata=0, no state change. Same-cycle trap + RW mepc -> mepc=trap_pc.
- CSR_MCYCLE_EN: write 0xB00=0xFFFF_FFFF, then wait 1 cycle -> 0xB80 increments by 1. Reset mid-RESP -> rsp_valid=0 asynchronously.

Source files
------------

// File: rtl/ysyx_25030093_csr_pkg.sv
// Shared definitions for the machine-mode CSR file: address map, op/state encodings, mstatus fields.
package ysyx_25030093_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    typedef enum logic [1:0] {
        OP_READ = 2'd0,
        OP_RW   = 2'd1,
        OP_RS   = 2'd2,
        OP_RC   = 2'd3
    } csr_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRV_M          = 2'b11;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;
    localparam int         CAUSE_ECALL_M  = 11;

    // Only direct (0) and vectored (1) are supported; reserved modes collapse to direct.
    function automatic logic [1:0] mtvec_mode_legal(input logic [1:0] mode);
        return mode[1] ? 2'b00 : mode;
    endfunction

endpackage

// File: rtl/ysyx_25030093_csr_alu.sv
// Combinational CSRRW/CSRRS/CSRRC new-value and write-enable computation.
module ysyx_25030093_csr_alu
    import ysyx_25030093_csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] new_val,
    output logic            wr_en
);

    always_comb begin
        new_val = old_val;
        wr_en   = 1'b0;
        case (csr_op_e'(op))
            OP_RW: begin
                new_val = wdata;
                wr_en   = 1'b1;
            end
            // Set/clear with a zero mask are pure reads.
            OP_RS: begin
                new_val = old_val | wdata;
                wr_en   = |wdata;
            end
            OP_RC: begin
                new_val = old_val & ~wdata;
                wr_en   = |wdata;
            end
            default: begin
                new_val = old_val;
                wr_en   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25030093_csr_file.sv
// Machine-mode CSR file: registered CSR access, trap entry, mret and fetch redirect.
// Define CSR_MCYCLE_EN to add the 64-bit mcycle counter at 0xB00/0xB80.
module ysyx_25030093_csr_file
    import ysyx_25030093_csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MSTATUS_RST = 'h0000_1800,
    parameter logic [XLEN-1:0] MTVEC_RST   = '0,
    parameter int              CAUSE_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [11:0]        req_addr,
    input  logic [XLEN-1:0]    req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [XLEN-1:0]    rsp_rdata,
    output logic               rsp_illegal,
    input  logic               trap_valid,
    input  logic               trap_intr,
    input  logic [CAUSE_W-1:0] trap_cause,
    input  logic [XLEN-1:0]    trap_pc,
    input  logic               mret_valid,
    output logic               redir_valid,
    output logic [XLEN-1:0]    redir_pc,
    output logic               mstatus_mie
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d, redir_pc_q, redir_pc_d;
    logic            rsp_illegal_q, rsp_illegal_d, redir_valid_q, redir_valid_d;

    logic            accept, csr_legal, alu_we, wr_en;
    logic [XLEN-1:0] csr_old, alu_new, trap_base;
`ifdef CSR_MCYCLE_EN
    logic [63:0]     mcycle_q, mcycle_d;
`endif

    assign accept = req_valid && (state_q == ST_IDLE);
    assign wr_en  = accept && csr_legal && alu_we && !trap_valid && !mret_valid;

    always_comb begin
        csr_old   = '0;
        csr_legal = 1'b1;
        case (req_addr)
            CSR_MSTATUS:  csr_old = mstatus_q;
            CSR_MTVEC:    csr_old = mtvec_q;
            CSR_MSCRATCH: csr_old = mscratch_q;
            CSR_MEPC:     csr_old = mepc_q;
            CSR_MCAUSE:   csr_old = mcause_q;
`ifdef CSR_MCYCLE_EN
            CSR_MCYCLE:   csr_old = mcycle_q[XLEN-1:0];
            CSR_MCYCLEH: begin
                if (XLEN == 32) csr_old = XLEN'(mcycle_q[63:32]);
                else            csr_legal = 1'b0;
            end
`endif
            default:      csr_legal = 1'b0;
        endcase
    end

    ysyx_25030093_csr_alu #(.XLEN(XLEN)) u_alu (
        .op      (req_op),
        .old_val (csr_old),
        .wdata   (req_wdata),
        .new_val (alu_new),
        .wr_en   (alu_we)
    );

    always_comb begin
        state_d       = state_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d       = ST_RESP;
                    rsp_rdata_d   = csr_old;
                    rsp_illegal_d = !csr_legal;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mstatus_d     = mstatus_q;
        mtvec_d       = mtvec_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mscratch_d    = mscratch_q;
        redir_valid_d = trap_valid || mret_valid;
        redir_pc_d    = redir_pc_q;
        trap_base     = {mtvec_q[XLEN-1:2], 2'b00};
        if (trap_valid) begin
            mepc_d                    = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d                  = {trap_intr, (XLEN-1)'(trap_cause)};
            mstatus_d[MSTATUS_MPIE]   = mstatus_q[MSTATUS_MIE];
            mstatus_d[MSTATUS_MIE]    = 1'b0;
            redir_pc_d = (mtvec_q[1:0] == MTVEC_VECTORED && trap_intr)
                       ? trap_base + (XLEN'(trap_cause) << 2) : trap_base;
        end else if (mret_valid) begin
            mstatus_d[MSTATUS_MIE]    = mstatus_q[MSTATUS_MPIE];
            mstatus_d[MSTATUS_MPIE]   = 1'b1;
            redir_pc_d                = mepc_q;
        end else if (wr_en) begin
            case (req_addr)
                CSR_MSTATUS:  mstatus_d  = alu_new;
                CSR_MTVEC:    mtvec_d    = {alu_new[XLEN-1:2], mtvec_mode_legal(alu_new[1:0])};
                CSR_MSCRATCH: mscratch_d = alu_new;
                CSR_MEPC:     mepc_d     = {alu_new[XLEN-1:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = alu_new;
                default: ;
            endcase
        end
        // Only M-mode exists, so MPP is hardwired to M (mret's MPP=0 reads back as 3).
        mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_M;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mstatus_q     <= MSTATUS_RST;
            mtvec_q       <= MTVEC_RST;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mscratch_q    <= '0;
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            mstatus_q     <= mstatus_d;
            mtvec_q       <= mtvec_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mscratch_q    <= mscratch_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_illegal_q <= rsp_illegal_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

`ifdef CSR_MCYCLE_EN
    // A written half replaces that cycle's increment; the other half keeps the carried count.
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (wr_en && req_addr == CSR_MCYCLE)  mcycle_d[XLEN-1:0] = alu_new;
        if (wr_en && req_addr == CSR_MCYCLEH) mcycle_d[63:32]    = alu_new[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mcycle_q <= '0;
        else     mcycle_q <= mcycle_d;
    end
`endif

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_illegal = rsp_illegal_q;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign mstatus_mie = mstatus_q[MSTATUS_MIE];

endmodule

// File: tb/tb_ysyx_25030093_csr_file.sv
// Self-checking bench for ysyx_25030093_csr_file: directed scenarios plus a randomized run against a reference model.
module tb_ysyx_25030093_csr_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1, rsp_illegal;
    logic [1:0]  req_op = 2'd0;
    logic [11:0] req_addr = 12'h0;
    logic [31:0] req_wdata = '0, rsp_rdata, trap_pc = '0, redir_pc;
    logic        trap_valid = 1'b0, trap_intr = 1'b0, mret_valid = 1'b0, redir_valid, mstatus_mie;
    logic [4:0]  trap_cause = '0;

    int checks = 0;
    int errors = 0;

    // Reference architectural state; MPP is stored raw and forced to 3 on read.
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mscratch;

    ysyx_25030093_csr_file dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
        .trap_valid(trap_valid), .trap_intr(trap_intr), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_valid(mret_valid), .redir_valid(redir_valid), .redir_pc(redir_pc), .mstatus_mie(mstatus_mie)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic rv, input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         input logic tv, input logic ti, input logic [4:0] tc, input logic [31:0] tp, input logic mv);
        req_valid = rv; req_op = op; req_addr = addr; req_wdata = wd;
        trap_valid = tv; trap_intr = ti; trap_cause = tc; trap_pc = tp; mret_valid = mv;
        tick();
        req_valid = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0;
    endtask

    task automatic csr_wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        rsp_ready = 1'b1;
        drive(1'b1, op, addr, wd, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic csr_rd(input logic [11:0] addr, output logic [31:0] data);
        rsp_ready = 1'b1;
        drive(1'b1, 2'd0, addr, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        data = rsp_rdata;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0 || rsp_illegal !== 1'b0) begin errors++; $display("FAIL reset_rsp got %h/%b exp 0/0", rsp_rdata, rsp_illegal); end
        checks++; if (redir_valid !== 1'b0 || redir_pc !== 32'h0) begin errors++; $display("FAIL reset_redir got %b/%h exp 0/0", redir_valid, redir_pc); end
        @(negedge clk); rst = 1'b0;
        tick();
        rsp_ready = 1'b1;
        drive(1'b1, 2'd0, 12'h300, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL read_latency rsp_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h1800 || rsp_illegal !== 1'b0) begin errors++; $display("FAIL reset_mstatus got %h/%b exp 1800/0", rsp_rdata, rsp_illegal); end
        tick();
        csr_rd(12'h305, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mtvec got %h exp 0", d); end
    endtask

`ifdef CSR_MCYCLE_EN
    task automatic test_mcycle();
        logic [31:0] d;
        csr_rd(12'hB80, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mcycleh_start got %h exp 0", d); end
        csr_wr(2'd1, 12'hB00, 32'hFFFF_FFFF);
        csr_rd(12'hB80, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL mcycle_carry got %h exp 1", d); end
        csr_rd(12'hB00, d);
        checks++; if (d > 32'd16) begin errors++; $display("FAIL mcycle_wrap got %h exp small", d); end
    endtask
`endif

    task automatic test_vectored_trap();
        logic [31:0] d;
        csr_wr(2'd1, 12'h305, 32'h8000_0001);
        drive(1'b0, 2'd0, 12'h0, 32'h0, 1'b1, 1'b1, 5'd7, 32'h8000_0040, 1'b0);
        checks++; if (redir_valid !== 1'b1 || redir_pc !== 32'h8000_001C) begin errors++; $display("FAIL vec_trap_redir got %b/%h exp 1/8000001c", redir_valid, redir_pc); end
        checks++; if (mstatus_mie !== 1'b0) begin errors++; $display("FAIL vec_trap_mie got %b exp 0", mstatus_mie); end
        tick();
        checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL redir_pulse got %b exp 0", redir_valid); end
        csr_rd(12'h342, d);
        checks++; if (d !== 32'h8000_0007) begin errors++; $display("FAIL vec_trap_mcause got %h exp 80000007", d); end
        csr_rd(12'h341, d);
        checks++; if (d !== 32'h8000_0040) begin errors++; $display("FAIL vec_trap_mepc got %h exp 80000040", d); end
    endtask

    task automatic test_ecall_mret();
        logic [31:0] d;
        csr_wr(2'd1, 12'h305, 32'h8000_0000);
        csr_wr(2'd1, 12'h300, 32'h0000_1808);
        checks++; if (mstatus_mie !== 1'b1) begin errors++; $display("FAIL mie_write got %b exp 1", mstatus_mie); end
        drive(1'b0, 2'd0, 12'h0, 32'h0, 1'b1, 1'b0, 5'd11, 32'h8000_0100, 1'b0);
        checks++; if (redir_valid !== 1'b1 || redir_pc !== 32'h8000_0000) begin errors++; $display("FAIL ecall_redir got %b/%h exp 1/80000000", redir_valid, redir_pc); end
        tick();
        csr_rd(12'h300, d);
        checks++; if (d !== 32'h0000_1880) begin errors++; $display("FAIL ecall_mstatus got %h exp 1880", d); end
        drive(1'b0, 2'd0, 12'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        checks++; if (redir_valid !== 1'b1 || redir_pc !== 32'h8000_0100) begin errors++; $display("FAIL mret_redir got %b/%h exp 1/80000100", redir_valid, redir_pc); end
        tick();
        csr_rd(12'h300, d);
        checks++; if (d !== 32'h0000_1888 || mstatus_mie !== 1'b1) begin errors++; $display("FAIL mret_mstatus got %h/%b exp 1888/1", d, mstatus_mie); end
        csr_wr(2'd1, 12'h305, 32'h8000_0006);
        csr_rd(12'h305, d);
        checks++; if (d !== 32'h8000_0004) begin errors++; $display("FAIL mtvec_mode_legal got %h exp 80000004", d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        csr_wr(2'd1, 12'h340, 32'h0000_000F);
        rsp_ready = 1'b0;
        drive(1'b1, 2'd2, 12'h340, 32'h0000_00F0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'h0F) begin
                errors++; $display("FAIL hold_%0d got v=%b rdy=%b d=%h exp 1/0/0000000f", i, rsp_valid, req_ready, rsp_rdata); end
            if (i == 1) drive(1'b0, 2'd0, 12'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
            else tick();
        end
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0F) begin errors++; $display("FAIL mret_in_resp got %b/%h exp 1/0000000f", rsp_valid, rsp_rdata); end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL resp_release got %b/%b exp 0/1", rsp_valid, req_ready); end
        csr_rd(12'h340, d);
        checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL rs_mscratch got %h exp ff", d); end
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        rsp_ready = 1'b1;
        drive(1'b1, 2'd1, 12'h7C0, 32'h1234_5678, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++; if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL illegal_rsp got %b/%b/%h exp 1/1/0", rsp_valid, rsp_illegal, rsp_rdata); end
        tick();
`ifndef CSR_MCYCLE_EN
        drive(1'b1, 2'd0, 12'hB00, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++; if (rsp_illegal !== 1'b1) begin errors++; $display("FAIL mcycle_absent got %b exp 1", rsp_illegal); end
        tick();
`endif
        csr_rd(12'h340, d);
        checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL illegal_nowrite got %h exp ff", d); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        rsp_ready = 1'b1;
        drive(1'b1, 2'd1, 12'h341, 32'h0000_1234, 1'b1, 1'b0, 5'd2, 32'h8000_0203, 1'b0);
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8000_0100 || rsp_illegal !== 1'b0) begin
            errors++; $display("FAIL trap_req_rsp got %b/%h/%b exp 1/80000100/0", rsp_valid, rsp_rdata, rsp_illegal); end
        checks++; if (redir_pc !== 32'h8000_0004) begin errors++; $display("FAIL trap_req_redir got %h exp 80000004", redir_pc); end
        tick();
        csr_rd(12'h341, d);
        checks++; if (d !== 32'h8000_0200) begin errors++; $display("FAIL trap_beats_write got %h exp 80000200", d); end
        drive(1'b1, 2'd1, 12'h340, 32'h55, 1'b1, 1'b0, 5'd3, 32'h8000_0300, 1'b1);
        checks++; if (redir_pc !== 32'h8000_0004) begin errors++; $display("FAIL trap_beats_mret got %h exp 80000004", redir_pc); end
        tick();
        csr_rd(12'h300, d);
        checks++; if (d !== 32'h0000_1800) begin errors++; $display("FAIL trap_mret_mstatus got %h exp 1800", d); end
        csr_rd(12'h340, d);
        checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL trap_mret_nowrite got %h exp ff", d); end
    endtask

    task automatic test_reset_mid_resp();
        logic [31:0] d;
        rsp_ready = 1'b0;
        drive(1'b1, 2'd0, 12'h340, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL async_reset got %b/%b/%h exp 0/1/0", rsp_valid, req_ready, rsp_rdata); end
        @(negedge clk); rst = 1'b0;
        tick();
        csr_rd(12'h340, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mscratch got %h exp 0", d); end
    endtask

    function automatic logic m_legal(input logic [11:0] a);
        return a == 12'h300 || a == 12'h305 || a == 12'h340 || a == 12'h341 || a == 12'h342;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus | 32'h1800;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    task automatic test_random();
        logic [11:0] addrs [7] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0, 12'h301};
        logic        rv, tv, ti, mv, ex_legal;
        logic [1:0]  op;
        logic [11:0] a;
        logic [31:0] wd, tp, old, nv, ex_pc;
        logic [4:0]  tc;
        int          r;
        do_reset();
        m_mstatus = 32'h1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            op = 2'($urandom);
            a  = addrs[$urandom_range(0, 6)];
            wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            r  = $urandom_range(0, 9);
            tv = (r <= 1);
            mv = (r == 1 || r == 2);
            ti = 1'($urandom); tc = 5'($urandom); tp = $urandom;
            ex_legal = m_legal(a);
            old = m_read(a);
            if (tv) ex_pc = (m_mtvec[1:0] == 2'b01 && ti) ? (m_mtvec & ~32'h3) + 32'(tc) * 4 : (m_mtvec & ~32'h3);
            else    ex_pc = m_mepc;
            drive(rv, op, a, wd, tv, ti, tc, tp, mv);
            if (rv) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_illegal !== !ex_legal || rsp_rdata !== (ex_legal ? old : 32'h0)) begin
                    errors++; $display("FAIL rand_rsp[%0d] addr %h got %b/%b/%h exp 1/%b/%h", i, a, rsp_valid, rsp_illegal, rsp_rdata, !ex_legal, ex_legal ? old : 32'h0); end
            end
            checks++; if (redir_valid !== (tv | mv) || ((tv | mv) && redir_pc !== ex_pc)) begin
                errors++; $display("FAIL rand_redir[%0d] got %b/%h exp %b/%h", i, redir_valid, redir_pc, tv | mv, ex_pc); end
            if (tv) begin
                m_mepc = tp & ~32'h3;
                m_mcause = {ti, 26'h0, tc};
                m_mstatus[7] = m_mstatus[3]; m_mstatus[3] = 1'b0; m_mstatus[12:11] = 2'b11;
            end else if (mv) begin
                m_mstatus[3] = m_mstatus[7]; m_mstatus[7] = 1'b1; m_mstatus[12:11] = 2'b00;
            end else if (rv && ex_legal && op != 2'd0 && !(op >= 2'd2 && wd == 32'h0)) begin
                nv = (op == 2'd1) ? wd : (op == 2'd2) ? (old | wd) : (old & ~wd);
                case (a)
                    12'h300: m_mstatus = nv;
                    12'h305: m_mtvec = nv[1] ? (nv & ~32'h3) : nv;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & ~32'h3;
                    default: m_mcause = nv;
                endcase
            end
            checks++; if (mstatus_mie !== m_mstatus[3]) begin errors++; $display("FAIL rand_mie[%0d] got %b exp %b", i, mstatus_mie, m_mstatus[3]); end
            if (rv) tick();
        end
    endtask

    initial begin
        test_reset();
`ifdef CSR_MCYCLE_EN
        test_mcycle();
`endif
        test_vectored_trap();
        test_ecall_mret();
        test_backpressure();
        test_illegal();
        test_priority();
        test_reset_mid_resp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
